pipe_div_param: RTL and testbench
=================================

Name: pipe_div_param

Overview:
- Parametrised, fully pipelined unsigned restoring divider: Q = A / B, R = A % B.
- One quotient bit resolved per stage; accepts one operation per cycle.
- Adds valid/ready flow control, remainder output and a divide-by-zero flag.
- Sits in arithmetic datapaths that need high-throughput division with back-pressure.

Parameters:
DW, 16, dividend and quotient width (>=2); pipeline depth = DW stages
VW, 8, divisor and remainder width (1..DW)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  operand pair present
in_ready  out  1  pipeline can accept this cycle
a  in  DW  dividend
b  in  VW  divisor
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
q  out  DW  quotient
r  out  VW  remainder
dbz  out  1  result came from b==0

Behaviour:
- Reset (rst low, asynchronous): every stage valid bit cleared; out_valid=0, q=0, r=0, dbz=0. Data registers may also clear. Deassertion is synchronised externally.
- Advance enable: en = !out_valid || out_ready. in_ready = en (combinational, no dependence on in_valid).
- Capture and shift:
  - Input is accepted when in_valid && in_ready.
  - When en=1, all stages shift one position.
  - Stage 1 loads {in_valid, a, b, b==0}.
  - When en=0, all stages hold their contents.
- Bubbles are not collapsed: an empty stage shifts like data.
- Latency: exactly DW cycles from acceptance to out_valid when en stays high. Each stall cycle adds one cycle.
- Stage k (k=1..DW) computes quotient bit DW-k:
  - Form the trial value t = {partial remainder (VW bits), next dividend bit}, VW+1 bits wide.
  - If t >= {1'b0,b}: quotient bit = 1 and the new partial remainder = t - b (fits VW bits).
  - Otherwise: quotient bit = 0 and the new partial remainder = t[VW-1:0].
  - The initial partial remainder is 0.
- Each stage register carries: valid, partial remainder (VW), shifted dividend/quotient (DW), divisor (VW), dbz.
- Output: q and r are driven from the last stage. They are held stable while out_valid && !out_ready.
- Divide by zero (b==0): q = all ones, r = 0, dbz=1. The override is applied at the output stage; latency is unchanged.
- Results leave in acceptance order; no reordering, loss or duplication under any out_ready pattern.
- Simultaneous output handshake and input accept in the same cycle is legal and gives a throughput of 1 per cycle.
- Reset mid-operation: all in-flight operations are discarded and out_valid drops immediately (asynchronously).
- Width rules:
  - Quotient is exact for all a in [0, 2^DW-1] and b in [1, 2^VW-1].
  - When VW=DW the trial value is DW+1 bits and no overflow occurs.

Optional Feature:
PIPE_DIV_SIGNED_EN
- Defined:
  - a, b, q and r are two's complement.
  - A pre-stage registers |a| and |b| together with the sign flags.
  - A post-stage negates: q is negated if sign(a)!=sign(b); r takes the sign of a.
  - Division truncates toward zero.
  - Latency is DW+2, and both extra stages obey the same en stall.
  - Most-negative a divided by -1 yields q = most-negative value with wrap-around and no flag.
  - b==0 gives q = all ones, r = 0, dbz=1.
- Undefined: unsigned behaviour as above, latency DW.

Test Plan:
- DW=16, VW=8, out_ready=1: a=1000, b=7 -> q=142, r=6, dbz=0, with out_valid exactly 16 cycles after acceptance.
- Boundary values:
  - a=65535, b=255 -> q=257, r=0.
  - a=5, b=9 -> q=0, r=5.
  - a=0, b=1 -> q=0, r=0.
- a=1234, b=0 -> q=16'hFFFF, r=0, dbz=1; the next operation a=100, b=3 -> q=33, r=1, dbz=0.
- Stream 64 random pairs back-to-back with out_ready driven by a random 50% pattern -> all 64 results match the reference model in order. in_ready equals !out_valid||out_ready every cycle. q/r stay stable during stalls.
- Reset mid-flight: accept 5 operations, assert rst on cycle 3 -> out_valid=0 immediately and no stale result appears after release. A fresh operation a=200, b=10 -> q=20, r=0.
- With PIPE_DIV_SIGNED_EN:
  - a=-1000, b=7 -> q=-142, r=-6.
  - a=1000, b=-7 -> q=-142, r=6.
  - Latency is 18 cycles.

Source files
------------

// File: rtl/pipe_div_param.sv
// Fully pipelined restoring divider (q = a / b, r = a % b), one quotient bit per stage,
// with valid/ready back-pressure. Define PIPE_DIV_SIGNED_EN for two's-complement operands.
module pipe_div_param #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          dbz
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The whole pipe advances together (en); bubbles are shifted, never collapsed.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic          head_valid;
  logic          head_dbz;
  logic [DW-1:0] head_a;
  logic [VW-1:0] head_b;

  logic          src_valid [DW];
  logic          src_dbz   [DW];
  logic [VW-1:0] src_rem   [DW];
  logic [VW-1:0] src_b     [DW];
  logic [DW-1:0] src_dq    [DW];
  logic [VW-1:0] nxt_rem   [DW];
  logic [DW-1:0] nxt_dq    [DW];

  logic          st_valid  [DW];
  logic          st_dbz    [DW];
  logic [VW-1:0] st_rem    [DW];
  logic [VW-1:0] st_b      [DW];
  logic [DW-1:0] st_dq     [DW];

  logic [VW:0]   trial;
  logic          take;

`ifdef PIPE_DIV_SIGNED_EN
  logic head_nq;
  logic head_nr;
  logic src_nq [DW];
  logic src_nr [DW];
  logic st_nq  [DW];
  logic st_nr  [DW];

  // Pre-stage: magnitudes plus the sign corrections the post-stage will apply.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_valid <= 1'b0;
      head_dbz   <= 1'b0;
      head_a     <= '0;
      head_b     <= '0;
      head_nq    <= 1'b0;
      head_nr    <= 1'b0;
    end else if (en) begin
      head_valid <= in_valid;
      head_dbz   <= (b == '0);
      head_a     <= a[DW-1] ? -a : a;
      head_b     <= b[VW-1] ? -b : b;
      head_nq    <= a[DW-1] ^ b[VW-1];
      head_nr    <= a[DW-1];
    end
  end
`else
  assign head_valid = in_valid;
  assign head_dbz   = (b == '0);
  assign head_a     = a;
  assign head_b     = b;
`endif

  always_comb begin
    src_valid[0] = head_valid;
    src_dbz[0]   = head_dbz;
    src_rem[0]   = '0;
    src_b[0]     = head_b;
    src_dq[0]    = head_a;
`ifdef PIPE_DIV_SIGNED_EN
    src_nq[0]    = head_nq;
    src_nr[0]    = head_nr;
`endif
    for (int k = 1; k < DW; k++) begin
      src_valid[k] = st_valid[k-1];
      src_dbz[k]   = st_dbz[k-1];
      src_rem[k]   = st_rem[k-1];
      src_b[k]     = st_b[k-1];
      src_dq[k]    = st_dq[k-1];
`ifdef PIPE_DIV_SIGNED_EN
      src_nq[k]    = st_nq[k-1];
      src_nr[k]    = st_nr[k-1];
`endif
    end
  end

  // When trial >= b the difference is below b, so the low VW bits of the subtraction are exact.
  always_comb begin
    trial = '0;
    take  = 1'b0;
    for (int k = 0; k < DW; k++) begin
      trial      = {src_rem[k], src_dq[k][DW-1]};
      take       = (trial >= {1'b0, src_b[k]});
      nxt_rem[k] = take ? (trial[VW-1:0] - src_b[k]) : trial[VW-1:0];
      nxt_dq[k]  = {src_dq[k][DW-2:0], take};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DW; k++) begin
        st_valid[k] <= 1'b0;
        st_dbz[k]   <= 1'b0;
        st_rem[k]   <= '0;
        st_b[k]     <= '0;
        st_dq[k]    <= '0;
`ifdef PIPE_DIV_SIGNED_EN
        st_nq[k]    <= 1'b0;
        st_nr[k]    <= 1'b0;
`endif
      end
    end else if (en) begin
      for (int k = 0; k < DW; k++) begin
        st_valid[k] <= src_valid[k];
        st_dbz[k]   <= src_dbz[k];
        st_rem[k]   <= nxt_rem[k];
        st_b[k]     <= src_b[k];
        st_dq[k]    <= nxt_dq[k];
`ifdef PIPE_DIV_SIGNED_EN
        st_nq[k]    <= src_nq[k];
        st_nr[k]    <= src_nr[k];
`endif
      end
    end
  end

`ifdef PIPE_DIV_SIGNED_EN
  // Post-stage: restore signs; most-negative / -1 wraps naturally through the negation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      q         <= '0;
      r         <= '0;
      dbz       <= 1'b0;
    end else if (en) begin
      out_valid <= st_valid[DW-1];
      dbz       <= st_dbz[DW-1];
      q         <= st_dbz[DW-1] ? '1 : (st_nq[DW-1] ? -st_dq[DW-1] : st_dq[DW-1]);
      r         <= st_dbz[DW-1] ? '0 : (st_nr[DW-1] ? -st_rem[DW-1] : st_rem[DW-1]);
    end
  end
`else
  assign out_valid = st_valid[DW-1];
  assign dbz       = st_dbz[DW-1];
  assign q         = st_dbz[DW-1] ? '1 : st_dq[DW-1];
  assign r         = st_dbz[DW-1] ? '0 : st_rem[DW-1];
`endif

endmodule

// File: tb/tb_pipe_div_param.sv
// Directed and streamed checks of pipe_div_param (DW=16, VW=8): latency, boundaries,
// divide-by-zero, back-pressure ordering/stability and asynchronous reset mid-flight.
module tb_pipe_div_param;
  localparam int DW = 16;
  localparam int VW = 8;
`ifdef PIPE_DIV_SIGNED_EN
  localparam int LAT = DW + 2;
`else
  localparam int LAT = DW;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [VW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] q;
  logic [VW-1:0] r;
  logic          dbz;

  int n_vec = 0;
  int n_err = 0;
  logic [DW+VW:0] exp_q[$];

  pipe_div_param #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .r(r), .dbz(dbz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW+VW:0] model(input logic [DW-1:0] av, input logic [VW-1:0] bv);
    logic [DW-1:0] mq;
    logic [VW-1:0] mr;
    if (bv == '0) return {{DW{1'b1}}, {VW{1'b0}}, 1'b1};
`ifdef PIPE_DIV_SIGNED_EN
    begin
      int ia;
      int ib;
      ia = int'($signed(av));
      ib = int'($signed(bv));
      mq = DW'(ia / ib);
      mr = VW'(ia % ib);
    end
`else
    mq = av / DW'(bv);
    mr = VW'(av % DW'(bv));
`endif
    return {mq, mr, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_wait(input logic [DW-1:0] av, input logic [VW-1:0] bv,
                           input logic [DW-1:0] eq, input logic [VW-1:0] er,
                           input logic ed, input string tag);
    int lat;
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check({tag, "_q"}, 32'(q), 32'(eq));
    check({tag, "_r"}, 32'(r), 32'(er));
    check({tag, "_dbz"}, 32'(dbz), 32'(ed));
    @(posedge clk); #1;
    check({tag, "_drain"}, 32'(out_valid), 32'(0));
  endtask

  initial begin
    logic [DW-1:0]  cur_a;
    logic [VW-1:0]  cur_b;
    logic [DW+VW:0] e;
    logic [DW+VW-1:0] prev_qr;
    logic stall_prev;
    int sent, got, cyc, stale;

    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_q", 32'(q), 32'(0));
    check("rst_r", 32'(r), 32'(0));
    check("rst_dbz", 32'(dbz), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;

    send_wait(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, "d1000_7");
`ifdef PIPE_DIV_SIGNED_EN
    send_wait(16'hFFFF, 8'hFF, 16'd1, 8'd0, 1'b0, "dm1_m1");
    send_wait(16'hFC18, 8'd7, 16'hFF72, 8'hFA, 1'b0, "dneg_a");
    send_wait(16'd1000, 8'hF9, 16'hFF72, 8'd6, 1'b0, "dneg_b");
    send_wait(16'h8000, 8'hFF, 16'h8000, 8'd0, 1'b0, "dmin_m1");
`else
    send_wait(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, "dmax");
`endif
    send_wait(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, "d5_9");
    send_wait(16'd0, 8'd1, 16'd0, 8'd0, 1'b0, "d0_1");
    send_wait(16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, "dbz");
    send_wait(16'd100, 8'd3, 16'd33, 8'd1, 1'b0, "after_dbz");

    // Back-to-back stream under random back-pressure.
    sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; prev_qr = '0;
    cur_a = DW'($urandom_range(0, 65535));
    cur_b = VW'($urandom_range(0, 255));
    while (got < 64 && cyc < 3000) begin
      in_valid  = (sent < 64);
      a         = cur_a;
      b         = cur_b;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (stall_prev) check("stall_hold", 32'({q, r}), 32'(prev_qr));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("stream", 32'({q, r, dbz}), 32'(e));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(cur_a, cur_b));
        sent++;
        cur_a = DW'($urandom_range(0, 65535));
        cur_b = VW'($urandom_range(0, 255));
      end
      stall_prev = out_valid && !out_ready;
      prev_qr    = {q, r};
      @(posedge clk); #1;
      cyc++;
    end
    check("stream_count", 32'(got), 32'(64));
    in_valid = 1'b0;

    // Reset while results are leaving the pipe.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = DW'($urandom_range(0, 65535));
      b = VW'($urandom_range(1, 255));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_valid", 32'(out_valid), 32'(1));
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'(0));
    check("async_rst_qr", 32'({q, r, dbz}), 32'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    stale = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("no_stale", 32'(stale), 32'(0));
    send_wait(16'd200, 8'd10, 16'd20, 8'd0, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
